// File: rtl/washing_cycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : washing_cycle_ctrl_if
// Description : Control and status bundle between the programme sequencer
//               and its environment (user inputs, washing counter, actuators).
// Revision    : 1.0 - initial release
// ============================================================================
interface washing_cycle_ctrl_if;
   logic       coin_in;
   logic       double_wash;
   logic       timer_pause;
   logic [1:0] clk_freq;
   logic       washing_done;
   logic       soft_rst;
   logic       start_washing;
   logic       round2_washing;
   logic       water_valve;
   logic       motor_spin;
   logic       busy;
   logic       cycle_done;
   logic [2:0] phase;

   // Environment side: drives requests, observes status.
   modport master (
      output coin_in, double_wash, timer_pause, clk_freq, washing_done,
      input  soft_rst, start_washing, round2_washing, water_valve,
             motor_spin, busy, cycle_done, phase
   );

   // Sequencer side.
   modport slave (
      input  coin_in, double_wash, timer_pause, clk_freq, washing_done,
      output soft_rst, start_washing, round2_washing, water_valve,
             motor_spin, busy, cycle_done, phase
   );
endinterface
`default_nettype wire

// File: rtl/washing_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : washing_cycle_ctrl
// Description : Washing machine programme sequencer
//               IDLE -> FILL -> WASH -> RINSE -> SPIN -> IDLE.
//               Optional macro WASH_WATCHDOG_EN adds a WASH watchdog that
//               traps into FAULT (exit via rst_n only).
// Revision    : 1.0 - initial release
// ============================================================================
module washing_cycle_ctrl #(
   parameter int unsigned TICKS_BASE = 1_000_000,
   parameter int unsigned FILL_SEC   = 60,
   parameter int unsigned RINSE_SEC  = 120,
   parameter int unsigned SPIN_SEC   = 60,
   parameter logic [31:0] WD_LIMIT   = 32'hFFFF_FFF0
) (
   input  wire logic          clk,
   input  wire logic          rst_n,
   washing_cycle_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FILL  = 3'd1,
      ST_WASH  = 3'd2,
      ST_RINSE = 3'd3,
      ST_SPIN  = 3'd4,
      ST_FAULT = 3'd5
   } state_t;

   localparam logic [31:0] C_FILL_BASE  = FILL_SEC  * TICKS_BASE;
   localparam logic [31:0] C_RINSE_BASE = RINSE_SEC * TICKS_BASE;
   localparam logic [31:0] C_SPIN_BASE  = SPIN_SEC  * TICKS_BASE;

   state_t      r_state;
   logic [31:0] r_timer;
   logic        r_dw;        // double_wash captured at coin acceptance
   logic        r_round;     // second round already requested
   logic [1:0]  r_ign;       // washing_done blanking after a round restart
   logic        r_soft_rst;
   logic        r_start_washing;
   logic        r_round2;
   logic        r_water_valve;
   logic        r_motor_spin;
   logic        r_busy;
   logic        r_cycle_done;
   logic [2:0]  r_phase;

   state_t      w_nxt;
   logic        w_r2_fire;
   logic [31:0] w_tgt;
   logic        w_expired;

`ifdef WASH_WATCHDOG_EN
   logic [31:0] r_wd;
`else
   // WD_LIMIT only matters when the watchdog is built in.
   if (WD_LIMIT == 32'd0) begin : g_wd_unused
   end
`endif

   // Phase duration for the timed states, scaled by the clock-rate select.
   always_comb begin
      case (r_state)
         ST_RINSE: w_tgt = C_RINSE_BASE << bus.clk_freq;
         ST_SPIN:  w_tgt = C_SPIN_BASE  << bus.clk_freq;
         default:  w_tgt = C_FILL_BASE  << bus.clk_freq;
      endcase
      w_expired = (r_timer >= (w_tgt - 32'd1));
   end

   // Next-state decision and round-restart request.
   always_comb begin
      w_nxt     = r_state;
      w_r2_fire = 1'b0;
      case (r_state)
         ST_IDLE:  if (bus.coin_in) w_nxt = ST_FILL;
         ST_FILL:  if (w_expired) w_nxt = ST_WASH;
         ST_WASH: begin
            if (bus.washing_done && (r_ign == 2'd0)) begin
               if (r_dw && !r_round) w_r2_fire = 1'b1;
               else                  w_nxt     = ST_RINSE;
            end
`ifdef WASH_WATCHDOG_EN
            else if (r_wd >= (WD_LIMIT - 32'd1)) begin
               w_nxt = ST_FAULT;
            end
`endif
         end
         ST_RINSE: if (w_expired) w_nxt = ST_SPIN;
         // A paused SPIN never expires; the timer is frozen as well.
         ST_SPIN:  if (!bus.timer_pause && w_expired) w_nxt = ST_IDLE;
`ifdef WASH_WATCHDOG_EN
         ST_FAULT: w_nxt = ST_FAULT;
`endif
         default:  w_nxt = ST_IDLE;
      endcase
   end

   // State, phase timer, programme flags and registered Moore outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state         <= ST_IDLE;
         r_timer         <= 32'd0;
         r_dw            <= 1'b0;
         r_round         <= 1'b0;
         r_ign           <= 2'd0;
         r_soft_rst      <= 1'b0;
         r_start_washing <= 1'b0;
         r_round2        <= 1'b0;
         r_water_valve   <= 1'b0;
         r_motor_spin    <= 1'b0;
         r_busy          <= 1'b0;
         r_cycle_done    <= 1'b0;
         r_phase         <= 3'd0;
      end else begin
         r_state <= w_nxt;

         if ((w_nxt != r_state) || (r_state == ST_IDLE))
            r_timer <= 32'd0;
         else if (!((r_state == ST_SPIN) && bus.timer_pause))
            r_timer <= r_timer + 32'd1;

         if ((r_state == ST_IDLE) && bus.coin_in) begin
            r_dw    <= bus.double_wash;
            r_round <= 1'b0;
            r_ign   <= 2'd0;
         end else if (w_r2_fire) begin
            // Blank washing_done during the pulse and the cycle after it,
            // while the counter restarts and drops its done flag.
            r_round <= 1'b1;
            r_ign   <= 2'd2;
         end else if (r_ign != 2'd0) begin
            r_ign   <= r_ign - 2'd1;
         end

         r_soft_rst      <= (w_nxt == ST_WASH) || (w_nxt == ST_RINSE);
         r_start_washing <= (w_nxt == ST_WASH);
         r_round2        <= w_r2_fire;
         r_water_valve   <= (w_nxt == ST_FILL) || (w_nxt == ST_RINSE);
         r_motor_spin    <= (w_nxt == ST_SPIN) && !bus.timer_pause;
         r_busy          <= (w_nxt != ST_IDLE);
         r_cycle_done    <= (r_state == ST_SPIN) && (w_nxt == ST_IDLE);
         r_phase         <= w_nxt;
      end
   end

`ifdef WASH_WATCHDOG_EN
   // WASH watchdog: counts WASH cycles, restarts with each new round.
   always_ff @(posedge clk) begin
      if (!rst_n)
         r_wd <= 32'd0;
      else if ((r_state == ST_WASH) && (w_nxt == ST_WASH) && !w_r2_fire)
         r_wd <= r_wd + 32'd1;
      else
         r_wd <= 32'd0;
   end
`endif

   assign bus.soft_rst       = r_soft_rst;
   assign bus.start_washing  = r_start_washing;
   assign bus.round2_washing = r_round2;
   assign bus.water_valve    = r_water_valve;
   assign bus.motor_spin     = r_motor_spin;
   assign bus.busy           = r_busy;
   assign bus.cycle_done     = r_cycle_done;
   assign bus.phase          = r_phase;

endmodule
`default_nettype wire

// File: tb/tb_washing_cycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_washing_cycle_ctrl
// Description : Directed, table-driven bench for washing_cycle_ctrl with
//               TICKS_BASE=10, FILL_SEC=2, RINSE_SEC=3, SPIN_SEC=1.
//               Watchdog sequence runs only with WASH_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_washing_cycle_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   int   n_chk = 0;
   int   n_err = 0;

   washing_cycle_ctrl_if ifc ();

   washing_cycle_ctrl #(
      .TICKS_BASE (10),
      .FILL_SEC   (2),
      .RINSE_SEC  (3),
      .SPIN_SEC   (1),
      .WD_LIMIT   (32'd50)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         n;
      logic       rst_n;
      logic       coin;
      logic       dw;
      logic       pause;
      logic [1:0] freq;
      logic       done;
      logic [9:0] exp;
   } vec_t;

   vec_t vt[11];

   // {phase, busy, valve, start, motor, soft_rst, round2, cycle_done}
   function automatic logic [9:0] mk(input logic [2:0] ph, input logic b,
                                     input logic v, input logic s,
                                     input logic m, input logic sr,
                                     input logic r2, input logic cd);
      return {ph, b, v, s, m, sr, r2, cd};
   endfunction

   function automatic logic [9:0] outs();
      return {ifc.phase, ifc.busy, ifc.water_valve, ifc.start_washing,
              ifc.motor_spin, ifc.soft_rst, ifc.round2_washing, ifc.cycle_done};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst_n               = 1'b0;
      ifc.coin_in         = 1'b0;
      ifc.double_wash     = 1'b0;
      ifc.timer_pause     = 1'b0;
      ifc.clk_freq        = 2'd0;
      ifc.washing_done    = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   // Pulse coin_in and flip double_wash afterwards; the flip must not matter.
   task automatic start_prog(input logic dw, input logic [1:0] freq);
      ifc.clk_freq    = freq;
      ifc.double_wash = dw;
      ifc.coin_in     = 1'b1;
      tick();
      ifc.coin_in     = 1'b0;
      ifc.double_wash = ~dw;
   endtask

   // Count consecutive observed cycles in phase p (current cycle included).
   task automatic measure(input int p, output int c);
      c = 0;
      while ((ifc.phase == 3'(p)) && (c < 2000)) begin
         c++;
         tick();
      end
   endtask

   int c;
   int cnt_a;
   int cnt_b;

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      // n, rst_n, coin, dw, pause, freq, done, expected outputs
      vt[0]  = '{2,  1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, mk(3'd0,0,0,0,0,0,0,0)};
      vt[1]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, mk(3'd1,1,1,0,0,0,0,0)};
      vt[2]  = '{19, 1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, mk(3'd1,1,1,0,0,0,0,0)};
      vt[3]  = '{1,  1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, mk(3'd2,1,0,1,0,1,0,0)};
      vt[4]  = '{10, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, mk(3'd2,1,0,1,0,1,0,0)};
      vt[5]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, mk(3'd3,1,1,0,0,1,0,0)};
      vt[6]  = '{29, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, mk(3'd3,1,1,0,0,1,0,0)};
      vt[7]  = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, mk(3'd4,1,0,0,1,0,0,0)};
      vt[8]  = '{9,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, mk(3'd4,1,0,0,1,0,0,0)};
      vt[9]  = '{1,  1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, mk(3'd0,0,0,0,0,0,0,1)};
      vt[10] = '{1,  1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, mk(3'd0,0,0,0,0,0,0,0)};

      do_reset();

      // T1: single wash applied as a vector table
      for (int i = 0; i < 11; i++) begin
         rst_n            = vt[i].rst_n;
         ifc.coin_in      = vt[i].coin;
         ifc.double_wash  = vt[i].dw;
         ifc.timer_pause  = vt[i].pause;
         ifc.clk_freq     = vt[i].freq;
         ifc.washing_done = vt[i].done;
         repeat (vt[i].n) tick();
         chk($sformatf("vec%0d", i), 32'(outs()), 32'(vt[i].exp));
      end

      // T1 durations measured directly
      do_reset();
      start_prog(1'b0, 2'd0);
      measure(1, c);
      chk("t1_fill_len", c, 20);
      repeat (3) tick();
      ifc.washing_done = 1'b1;
      tick();
      ifc.washing_done = 1'b0;
      measure(3, c);
      chk("t1_rinse_len", c, 30);
      measure(4, c);
      chk("t1_spin_len", c, 10);

      // T2: double wash, exactly one round2 pulse
      do_reset();
      start_prog(1'b1, 2'd0);
      repeat (20) tick();
      chk("t2_in_wash", 32'(ifc.phase), 32'd2);
      cnt_a = 0;
      ifc.washing_done = 1'b1;
      repeat (3) begin
         tick();
         if (ifc.round2_washing) cnt_a++;
      end
      chk("t2_wash_hold", 32'(ifc.phase), 32'd2);
      ifc.washing_done = 1'b0;
      repeat (4) begin
         tick();
         if (ifc.round2_washing) cnt_a++;
      end
      chk("t2_r2_count", cnt_a, 1);
      ifc.washing_done = 1'b1;
      tick();
      chk("t2_second_done", 32'(ifc.phase), 32'd3);
      chk("t2_no_r2_after", 32'(ifc.round2_washing), 32'd0);

      // T2b: double_wash=0 at coin gives no round2 pulse
      do_reset();
      start_prog(1'b0, 2'd0);
      repeat (20) tick();
      ifc.washing_done = 1'b1;
      tick();
      chk("t2b_to_rinse", 32'(ifc.phase), 32'd3);
      chk("t2b_no_r2", 32'(ifc.round2_washing), 32'd0);

      // T3: clk_freq=11 stretches FILL to 160 cycles
      do_reset();
      start_prog(1'b0, 2'd3);
      measure(1, c);
      chk("t3_fill_len_x8", c, 160);

      // T3b: drop clk_freq to 00 at cycle 50 of FILL, exit on next edge
      do_reset();
      start_prog(1'b0, 2'd3);
      repeat (49) tick();
      chk("t3b_still_fill", 32'(ifc.phase), 32'd1);
      ifc.clk_freq = 2'd0;
      tick();
      chk("t3b_exit", 32'(ifc.phase), 32'd2);

      // T4: 7-cycle pause mid-SPIN, coin ignored during SPIN
      do_reset();
      start_prog(1'b0, 2'd0);
      repeat (20) tick();
      ifc.washing_done = 1'b1;
      tick();
      ifc.washing_done = 1'b0;
      repeat (30) tick();
      chk("t4_in_spin", 32'(ifc.phase), 32'd4);
      c     = 0;
      cnt_a = 0;
      while ((ifc.phase == 3'd4) && (c < 200)) begin
         c++;
         if (!ifc.motor_spin) cnt_a++;
         ifc.timer_pause = (c >= 4) && (c < 11);
         ifc.coin_in     = (c == 6);
         tick();
      end
      ifc.timer_pause = 1'b0;
      ifc.coin_in     = 1'b0;
      chk("t4_spin_len", c, 17);
      chk("t4_motor_off", cnt_a, 7);
      chk("t4_cycle_done", 32'(ifc.cycle_done), 32'd1);
      tick();
      chk("t4_idle_after", 32'(outs()), 32'(mk(3'd0,0,0,0,0,0,0,0)));

      // T5: reset during RINSE (with coin_in) aborts without cycle_done
      do_reset();
      start_prog(1'b0, 2'd0);
      repeat (20) tick();
      ifc.washing_done = 1'b1;
      tick();
      ifc.washing_done = 1'b0;
      repeat (5) tick();
      rst_n       = 1'b0;
      ifc.coin_in = 1'b1;
      tick();
      chk("t5_reset_outs", 32'(outs()), 32'(mk(3'd0,0,0,0,0,0,0,0)));
      rst_n       = 1'b1;
      ifc.coin_in = 1'b0;
      cnt_a = 0;
      cnt_b = 0;
      repeat (60) begin
         tick();
         if (ifc.cycle_done) cnt_a++;
         if (ifc.phase != 3'd0) cnt_b++;
      end
      chk("t5_no_cycle_done", cnt_a, 0);
      chk("t5_stays_idle", cnt_b, 0);

`ifdef WASH_WATCHDOG_EN
      // T6: watchdog traps into FAULT after 50 WASH cycles
      do_reset();
      start_prog(1'b0, 2'd0);
      repeat (20) tick();
      measure(2, c);
      chk("t6_wash_len", c, 50);
      chk("t6_fault_outs", 32'(outs()), 32'(mk(3'd5,1,0,0,0,0,0,0)));
      ifc.coin_in = 1'b1;
      repeat (10) tick();
      ifc.coin_in = 1'b0;
      chk("t6_fault_hold", 32'(ifc.phase), 32'd5);
      do_reset();
      chk("t6_reset_exit", 32'(outs()), 32'(mk(3'd0,0,0,0,0,0,0,0)));
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
